// File: rtl/gray_addr_checker.sv
// Receive-side checker for a Gray-coded address stream: converts each new code to binary and
// flags Hamming-distance, sequence and cadence violations with sticky status and an event count.
module gray_addr_checker #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned FIRST_GAP = 5,
    parameter int unsigned STEP_GAP  = 4
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic             EN,
    input  logic [WIDTH-1:0] GRAY_IN,
    input  logic             CLR,
    output logic [WIDTH-1:0] BIN_OUT,
    output logic             BIN_VALID,
    output logic             HAM_ERR,
    output logic             SEQ_ERR,
    output logic             GAP_ERR,
    output logic [7:0]       ERR_CNT
);

    typedef enum logic [1:0] {StIdle, StArmed, StTrack} state_e;

    localparam logic [7:0] FirstGap = 8'(FIRST_GAP);
    localparam logic [7:0] StepGap  = 8'(STEP_GAP);

    function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = int'(WIDTH) - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    state_e           state_q, state_d;
    logic [7:0]       gap_q, gap_d;
    logic [WIDTH-1:0] prev_gray_q, prev_gray_d;
    logic [WIDTH-1:0] exp_bin_q, exp_bin_d;
    logic [WIDTH-1:0] bin_out_q, bin_out_d;
    logic             bin_valid_q, bin_valid_d;
    logic             ham_err_q, ham_err_d;
    logic             seq_err_q, seq_err_d;
    logic             gap_err_q, gap_err_d;
    logic [7:0]       err_cnt_q, err_cnt_d;

    logic [WIDTH-1:0] bin_in;
    logic [WIDTH-1:0] diff;
    logic             chg;
    logic [7:0]       req_gap;
    logic             ham_ev, seq_ev, gap_ev, any_ev;

    always_comb begin
        state_d     = state_q;
        gap_d       = gap_q;
        prev_gray_d = prev_gray_q;
        exp_bin_d   = exp_bin_q;
        bin_out_d   = bin_out_q;
        bin_valid_d = 1'b0;
        ham_ev      = 1'b0;
        seq_ev      = 1'b0;
        gap_ev      = 1'b0;

        bin_in  = gray2bin(GRAY_IN);
        diff    = GRAY_IN ^ prev_gray_q;
        chg     = EN && (diff != '0);
        req_gap = (state_q == StArmed) ? FirstGap : StepGap;

        if (!EN) begin
            // Pausing keeps the code history so the stream resumes seamlessly.
            state_d = StIdle;
            gap_d   = 8'd0;
        end else if (state_q == StIdle) begin
            state_d = StArmed;
            gap_d   = 8'd1;
        end else if (chg) begin
            state_d     = StTrack;
            bin_out_d   = bin_in;
            bin_valid_d = 1'b1;
            prev_gray_d = GRAY_IN;
            exp_bin_d   = bin_in + WIDTH'(1);
            gap_d       = 8'd1;
            // diff is non-zero here, so clearing its lowest set bit leaves zero only if one-hot.
            ham_ev      = |(diff & (diff - WIDTH'(1)));
            seq_ev      = (bin_in != exp_bin_q);
            gap_ev      = (gap_q != req_gap);
        end else begin
            gap_ev = (gap_q == req_gap);
            if (gap_q != 8'hFF) begin
                gap_d = gap_q + 8'd1;
            end
        end

        any_ev = ham_ev | seq_ev | gap_ev;

        if (CLR) begin
            ham_err_d = ham_ev;
            seq_err_d = seq_ev;
            gap_err_d = gap_ev;
            err_cnt_d = any_ev ? 8'd1 : 8'd0;
        end else begin
            ham_err_d = ham_err_q | ham_ev;
            seq_err_d = seq_err_q | seq_ev;
            gap_err_d = gap_err_q | gap_ev;
            err_cnt_d = (any_ev && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state_q     <= StIdle;
            gap_q       <= 8'd0;
            prev_gray_q <= '0;
            exp_bin_q   <= WIDTH'(1);
            bin_out_q   <= '0;
            bin_valid_q <= 1'b0;
            ham_err_q   <= 1'b0;
            seq_err_q   <= 1'b0;
            gap_err_q   <= 1'b0;
            err_cnt_q   <= 8'd0;
        end else begin
            state_q     <= state_d;
            gap_q       <= gap_d;
            prev_gray_q <= prev_gray_d;
            exp_bin_q   <= exp_bin_d;
            bin_out_q   <= bin_out_d;
            bin_valid_q <= bin_valid_d;
            ham_err_q   <= ham_err_d;
            seq_err_q   <= seq_err_d;
            gap_err_q   <= gap_err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign BIN_OUT   = bin_out_q;
    assign BIN_VALID = bin_valid_q;
    assign HAM_ERR   = ham_err_q;
    assign SEQ_ERR   = seq_err_q;
    assign GAP_ERR   = gap_err_q;
    assign ERR_CNT   = err_cnt_q;

endmodule

// File: doc/gray_addr_checker.md
# gray_addr_checker

Receive-side companion to the memory controller's Gray-code address generator. Samples a Gray-coded address bus and converts each new code to binary. Checks that the stream is a legal Gray sequence: one bit changes per step, binary value increments by one, and steps arrive on the generator's fixed cadence. Sits on the BIST/BISR address path and reports converted addresses plus sticky error status to the repair logic.

## Interface
- WIDTH, 16: address width in bits.
- FIRST_GAP, 5: required enabled-cycle gap from enable to the first code change.
- STEP_GAP, 4: required enabled-cycle gap between subsequent code changes.
- CLK  in  1  clock; all logic on the rising edge.
- RSTN  in  1  reset, synchronous, active-low.
- EN  in  1  enable; the same enable that drives the address generator.
- GRAY_IN  in  WIDTH  Gray-coded address from the generator.
- CLR  in  1  synchronous clear of error flags and ERR_CNT.
- BIN_OUT  out  WIDTH  binary address of the last accepted code.
- BIN_VALID  out  1  one-cycle pulse when BIN_OUT updates.
- HAM_ERR  out  1  sticky; a step changed more or less than one bit.
- SEQ_ERR  out  1  sticky; the decoded value was not previous+1 (mod 2^WIDTH).
- GAP_ERR  out  1  sticky; a step arrived early, late, or was missing.
- ERR_CNT  out  8  count of error events, saturating at 255.

## Operation
- Internal registers:
  - PREV_GRAY (WIDTH): last sampled code.
  - EXP_BIN (WIDTH): expected next binary value.
  - GAP (8 bit): enabled-cycle counter, saturating at 255.
  - State: IDLE, ARMED, TRACK.
- Conversion: bin[i] = XOR of gray[WIDTH-1:i]; bin[WIDTH-1] = gray[WIDTH-1].
- Change detect: CHG = EN and (GRAY_IN != PREV_GRAY). Sampled only while EN=1.
- IDLE:
  - On EN=1, go to ARMED and set GAP <= 1.
  - GRAY_IN is ignored and PREV_GRAY is held.
- ARMED:
  - On CHG, check GAP == FIRST_GAP, then go to TRACK.
  - With no CHG and GAP == FIRST_GAP, raise a missing-step GAP_ERR.
- TRACK:
  - On CHG, check GAP == STEP_GAP.
  - With no CHG and GAP == STEP_GAP, raise a missing-step GAP_ERR.
- On each CHG:
  - BIN_OUT <= bin(GRAY_IN), BIN_VALID <= 1, PREV_GRAY <= GRAY_IN.
  - EXP_BIN <= bin(GRAY_IN) + 1 (wraps).
  - GAP <= 1.
  - HAM_ERR if popcount(GRAY_IN ^ PREV_GRAY) != 1.
  - SEQ_ERR if bin(GRAY_IN) != EXP_BIN.
  - GAP_ERR if GAP differs from the state's required gap.
- With no CHG and EN=1: GAP <= GAP+1 (saturating).
- A late step produces two GAP_ERR events: the missing-step event and the wrong gap at arrival.
- EN=0 in any state:
  - Go to IDLE and clear GAP.
  - Hold BIN_OUT, PREV_GRAY and EXP_BIN, so the sequence continues across pauses.
  - Re-enable re-arms with the FIRST_GAP check.
- ERR_CNT adds 1 per cycle in which any error condition fires (one event even if several fire together), saturating at 255.
- Wrap-around: binary 0xFFFF (gray 0x8000) -> 0x0000 (gray 0x0000) is legal for WIDTH=16.
- CLR clears HAM_ERR, SEQ_ERR, GAP_ERR and ERR_CNT. An error firing in the same cycle as CLR wins: its flag is set and ERR_CNT = 1.

## Timing
- Reset values (RSTN=0 at an edge):
  - State = IDLE; all outputs 0; GAP = 0.
  - PREV_GRAY = 0; EXP_BIN = 1.
- Reset mid-operation discards all history; the next EN behaves as a first enable.
- Latency: a change of GRAY_IN sampled at edge k gives BIN_OUT/BIN_VALID/error flags valid after edge k (one register stage).
- BIN_VALID is high for exactly one cycle per accepted change; never high while EN=0.
- Nominal cadence with the generator enabled at edge 1:
  - First change sampled at edge 6 (GAP=5).
  - Then edges 10, 14, … (GAP=4).

## Test plan
- Reset, then EN=1 with the generator running 0,1,3,2,6 on cadence -> BIN_VALID at edges 6, 10, 14, 18; BIN_OUT 1, 2, 3, 4; all error flags 0; ERR_CNT 0.
- Code jump 0x0003 -> 0x0005 (two bits changed) -> HAM_ERR=1, SEQ_ERR=1, ERR_CNT=1, BIN_OUT=0x0006.
- Step 3 cycles early in TRACK -> GAP_ERR=1, ERR_CNT=1; BIN_OUT still updates.
- Step missing for 6 cycles -> GAP_ERR at GAP=4 (ERR_CNT=1), second event on late arrival (ERR_CNT=2).
- Preload the stream to gray 0x8000 then 0x0000 -> BIN_OUT 0xFFFF then 0x0000, no errors.
- EN drop mid-stream, re-enable after 7 cycles -> first change accepted at GAP=5 with no error; RSTN low mid-stream -> all outputs 0 the next cycle; CLR -> flags and ERR_CNT 0.
